// File: rtl/mul_div_ctrl.sv
// Multi-cycle MIPS multiply/divide sequencer that owns the architectural HI/LO registers.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator and take WIDTH steps.
module mul_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]        CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
    localparam logic [WIDTH-1:0]     ZERO_W   = WIDTH'(0);
    localparam logic [WIDTH-1:0]     ONES_W   = {WIDTH{1'b1}};
    localparam logic [2*WIDTH-1:0]   ONE_2W   = (2*WIDTH)'(1);
    localparam logic [2*WIDTH-1:0]   ZERO_2W  = (2*WIDTH)'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;

    logic               r_op_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_y_zero;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_x_raw;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_x_neg;
    logic               w_y_neg;
    logic [WIDTH-1:0]   w_x_mag;
    logic [WIDTH-1:0]   w_y_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    // Signed ops work on magnitudes; op[0] selects the signed variant.
    assign w_x_neg = op[0] & x[WIDTH-1];
    assign w_y_neg = op[0] & y[WIDTH-1];
    assign w_x_mag = w_x_neg ? (~x + ONE_W) : x;
    assign w_y_mag = w_y_neg ? (~y + ONE_W) : y;

    // Upper half gains the multiplicand when the LSB is set, then the whole accumulator shifts right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {1'b0, ZERO_W});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Upper half is the partial remainder, lower half shifts the dividend out and quotient bits in.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_next  = w_div_diff[WIDTH] ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                           : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = r_neg_res ? (~r_acc + ONE_2W) : r_acc;
    assign w_quo  = r_neg_res ? (~r_acc[WIDTH-1:0] + ONE_W) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + ONE_W) : r_acc[2*WIDTH-1:WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and operation accept strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CALC;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = S_FIX;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, iteration counter and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_y_zero   <= 1'b0;
            r_opnd     <= ZERO_W;
            r_x_raw    <= ZERO_W;
            r_acc      <= ZERO_2W;
            r_cnt      <= CNT_ZERO;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= ZERO_W;
            r_lo       <= ZERO_W;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (w_accept) begin
                        r_op_div   <= op[1];
                        r_neg_res  <= w_x_neg ^ w_y_neg;
                        r_neg_rem  <= w_x_neg;
                        r_y_zero   <= (y == ZERO_W);
                        r_x_raw    <= x;
                        r_opnd     <= op[1] ? w_y_mag : w_x_mag;
                        r_acc      <= {ZERO_W, (op[1] ? w_x_mag : w_y_mag)};
                        r_cnt      <= CNT_LAST;
                        r_busy     <= 1'b1;
                        r_div_zero <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_acc <= r_op_div ? w_div_next : w_mul_next;
                    if (r_cnt != CNT_ZERO) r_cnt <= r_cnt - CNT_ONE;
                end
                S_FIX: begin
                    // Divide-by-zero still runs the full iteration count so latency never depends on data.
                    if (r_op_div && r_y_zero) begin
                        r_hi <= r_x_raw;
                        r_lo <= ONES_W;
                    end else if (r_op_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_div_zero <= r_op_div & r_y_zero;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Directed bench for mul_div_ctrl: an arithmetic reference model checked every cycle,
// plus hand-computed result literals for each directed operation.
module tb_mul_div_ctrl;
    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          hi_we;
    logic          lo_we;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    mul_div_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .x        (x),
        .y        (y),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference result {div_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin
                u = {32'd0, a} * {32'd0, b};
                return {1'b0, u};
            end
            2'd1: begin
                p = sa * sb;
                return {1'b0, p[63:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 2'd2) return {1'b0, a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Model: an accepted op finishes WIDTH+1 edges later; MTHI/MTLO only land while idle.
    logic        m_busy;
    logic        m_done;
    logic        m_dz;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [64:0] m_res;
    int          m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= 1'b0;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_dz   <= m_res[64];
                m_hi   <= m_res[63:32];
                m_lo   <= m_res[31:0];
            end
        end else begin
            m_done <= 1'b0;
            if (hi_we) m_hi <= wdata;
            if (lo_we) m_lo <= wdata;
            if (start) begin
                m_res  <= ref_op(op, x, y);
                m_left <= W + 1;
                m_busy <= 1'b1;
                m_dz   <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", busy, m_busy);
            chk("model_done", done, m_done);
            chk("model_div_zero", div_zero, m_dz);
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        x     = a;
        y     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_op(input string nm, input int ebusy, input logic [31:0] ehi,
                             input logic [31:0] elo, input logic edz);
        int bcnt = 0;
        int cyc  = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) bcnt++;
            cyc++;
            @(negedge clk);
        end
        chk({nm, "_done_seen"}, (cyc < 100) ? 64'd1 : 64'd0, 64'd1);
        chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(ebusy));
        chk({nm, "_hi"}, hi, ehi);
        chk({nm, "_lo"}, lo, elo);
        chk({nm, "_div_zero"}, div_zero, edz);
    endtask

    initial begin
        int dcnt;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        x     = 32'd0;
        y     = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 64'd0);
        chk("reset_done", done, 64'd0);
        chk("reset_div_zero", div_zero, 64'd0);
        chk("reset_hi", hi, 64'd0);
        chk("reset_lo", lo, 64'd0);

        launch(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max", 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(negedge clk);
        chk("multu_done_single", done, 64'd0);

        // Each launch below asserts start in the done cycle of the previous op.
        launch(2'd1, 32'hFFFF_FFFD, 32'd5);
        finish_op("mult_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        launch(2'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        finish_op("mult_negneg", 33, 32'd0, 32'd6, 1'b0);
        launch(2'd3, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg_dividend", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        launch(2'd3, 32'd7, 32'hFFFF_FFFE);
        finish_op("div_neg_divisor", 33, 32'd1, 32'hFFFF_FFFD, 1'b0);
        launch(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_overflow", 33, 32'd0, 32'h8000_0000, 1'b0);
        launch(2'd3, 32'hFFFF_FFFB, 32'd0);
        finish_op("div_by_zero_signed", 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        launch(2'd2, 32'h64, 32'd0);
        finish_op("divu_by_zero", 33, 32'h64, 32'hFFFF_FFFF, 1'b1);

        // Mid-operation start and MTHI must both be dropped.
        launch(2'd0, 32'd7, 32'd9);
        chk("div_zero_cleared", div_zero, 64'd0);
        repeat (4) @(negedge clk);
        op    = 2'd2;
        x     = 32'd3;
        y     = 32'd3;
        wdata = 32'hDEAD;
        start = 1'b1;
        hi_we = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        chk("hi_stale_while_busy", hi, 64'h64);
        finish_op("multu_ignore_start", 28, 32'd0, 32'h3F, 1'b0);

        @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_idle", lo, 64'h1234);

        launch(2'd1, 32'd12345, 32'hFFFF_FF00);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 64'd0);
        chk("abort_hi", hi, 64'd0);
        chk("abort_lo", lo, 64'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);

        // MTHI on the accept edge lands, then the result overwrites it.
        hi_we = 1'b1;
        wdata = 32'hABCD;
        launch(2'd2, 32'd100, 32'd7);
        hi_we = 1'b0;
        chk("mthi_with_start", hi, 64'hABCD);
        finish_op("divu_after_abort", 33, 32'd2, 32'd14, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_ctrl.md
Name: mul_div_ctrl

Overview:
Multi-cycle sequencer for the MIPS multiply/divide instructions MULT, MULTU, DIV and DIVU, plus the MTHI and MTLO writes. It sits beside the single-cycle ALU and owns the architectural HI/LO registers. It runs an iterative shift-add multiplier or restoring divider for WIDTH cycles under a start/busy/done handshake. The pipeline stalls on busy and reads HI/LO for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request a new operation; accepted only when busy=0.
op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
x  in  WIDTH  multiplicand / dividend.
y  in  WIDTH  multiplier / divisor.
hi_we  in  1  MTHI write enable.
lo_we  in  1  MTLO write enable.
wdata  in  WIDTH  MTHI/MTLO data.
busy  out  1  operation in progress.
done  out  1  one-cycle completion pulse.
div_zero  out  1  divide-by-zero indicator; valid with done.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset values: busy=0, done=0, div_zero=0, hi=0, lo=0, state IDLE, iteration counter=0.
- Reset mid-operation aborts the operation immediately. All outputs take their reset values; no partial result reaches hi/lo.
- States and transitions:
  - IDLE to CALC on the edge with start=1 (edge 0).
  - CALC to FIX after WIDTH iterations.
  - FIX to IDLE after one cycle.
- Edge 0 (accept):
  - latch op, |x| and |y| (magnitudes for signed ops, raw values for unsigned), the result-sign and remainder-sign flags, and the y==0 flag;
  - busy goes to 1; counter loads WIDTH-1.
- Edges 1..WIDTH (CALC):
  - Multiply: one shift-add step per edge on a 2*WIDTH accumulator.
  - Divide: one restoring shift-subtract step per edge.
  - The counter decrements each edge; at 0 the state moves to FIX.
- Edge WIDTH+1 (FIX): apply sign correction, write hi/lo, pulse done=1 for exactly one cycle, busy goes to 0, state returns to IDLE.
- Latency: busy is high for WIDTH+1 cycles. done is visible in the cycle after edge WIDTH+1 (edge 33 for WIDTH=32). Latency is identical for all ops, including divide-by-zero.
- Result placement:
  - Multiply: hi = upper half of the 2*WIDTH product, lo = lower half. For MULT the product is negated (two's complement of the full 2*WIDTH value) when the operand signs differ.
  - Divide: lo = quotient, hi = remainder. Signed quotient is negated when the operand signs differ; signed remainder takes the dividend's sign. Quotient truncates toward zero.
  - DIV of most-negative by -1 gives lo=0x80000000, hi=0 (wraps, no flag).
- Divide by zero (y==0, DIV or DIVU): iterations still run for uniform timing, but FIX forces hi=x (original dividend), lo=all-ones, and div_zero=1 for the done cycle. div_zero is 0 on every other done and clears when the next operation is accepted.
- hi/lo hold their previous values throughout busy. Readers see stale values until done.
- start while busy=1 is ignored; the operands and op in flight are unaffected.
- hi_we/lo_we while busy=1 are dropped.
- hi_we/lo_we in IDLE write wdata on that edge.
- hi_we/lo_we on the same edge as an accepted start: the write takes effect, and the operation result overwrites it at FIX.
- done and start in the same cycle: the FIX edge returns to IDLE, so the start is accepted on the following edge. Back-to-back throughput is one op per WIDTH+2 cycles.

Test Plan:
1. MULTU x=0xFFFFFFFF, y=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. busy high for 33 cycles; done pulses exactly once after edge 33.
2. MULT x=0xFFFFFFFD (-3), y=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV x=0xFFFFFFF9 (-7), y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIV x=0x80000000, y=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0. DIVU x=0x64, y=0 -> hi=0x64, lo=0xFFFFFFFF, div_zero=1 with done, cleared on the next start.
4. Start a MULTU, then mid-op pulse start with different operands and assert hi_we -> both ignored; the original result is written; hi before done still shows the old value.
5. MTLO wdata=0x1234 in IDLE -> lo=0x1234 next cycle. Then assert rst at CALC iteration 10 -> busy=0, done never pulses, hi=lo=0. A fresh start afterwards completes normally.
